// File: rtl/cnn_layer_ctrl.sv
// Layer sequencer for the CNN PE array: walks every output tile, requests filter loads,
// prefetches IFM rows into a slot ring and drives vsync/hsync/data timing with indices.
`timescale 1ns/1ps
module cnn_layer_ctrl #(
  parameter int W_SIZE       = 9,
  parameter int W_CHANNEL    = 5,
  parameter int W_TILE       = 4,
  parameter int W_FRAME_SIZE = 2*W_SIZE+W_CHANNEL+W_TILE,
  parameter int W_DELAY      = 12,
  parameter int VSYNC_DELAY  = 16,
  parameter int HSYNC_DELAY  = 8,
  parameter int IFM_BUF_CNT  = 4,
  parameter int W_IFM_BUF    = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel,
  input  logic [W_TILE-1:0]       q_out_tiles,
  input  logic                    q_kernel3,
  input  logic                    q_stride2,
  input  logic                    q_filter_buf_done,
  input  logic                    q_ifm_buf_done,
  input  logic                    q_pe_done,
  output logic                    o_filter_buf_req_load,
  output logic                    o_ifm_buf_req_load,
  output logic [W_SIZE-1:0]       o_ifm_buf_req_row,
  output logic [W_IFM_BUF-1:0]    o_ifm_buf_req_slot,
  output logic                    o_ctrl_vsync_run,
  output logic                    o_ctrl_hsync_run,
  output logic                    o_ctrl_data_run,
  output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
  output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_TILE-1:0]       o_out_tile,
  output logic                    o_is_first_row,
  output logic                    o_is_last_row,
  output logic                    o_is_first_col,
  output logic                    o_is_last_col,
  output logic [W_FRAME_SIZE-1:0] o_data_count,
  output logic                    o_end_frame,
  output logic                    o_busy,
  output logic                    o_cfg_err
);

  localparam int WE = W_SIZE + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FLT, S_VSYNC, S_HSYNC, S_DATA, S_WAIT_PE, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [W_SIZE-1:0]       width_q, width_d, height_q, height_d;
  logic [W_CHANNEL-1:0]    chans_q, chans_d;
  logic [W_TILE-1:0]       tiles_q, tiles_d;
  logic                    kernel3_q, kernel3_d, stride2_q, stride2_d;
  logic [W_SIZE-1:0]       row_q, row_d, col_q, col_d;
  logic [W_CHANNEL-1:0]    chn_q, chn_d;
  logic [W_TILE-1:0]       tile_q, tile_d;
  logic [W_DELAY-1:0]      vcnt_q, vcnt_d, hcnt_q, hcnt_d;
  logic [W_FRAME_SIZE-1:0] dcount_q, dcount_d;
  logic                    pe_done_q, pe_done_d;
  logic [WE-1:0]           nlr_q, nlr_d, loaded_q, loaded_d;
  logic                    pend_q, pend_d, stale_q, stale_d;
  logic                    flt_req_q, flt_req_d, ifm_req_q, ifm_req_d;
  logic [W_SIZE-1:0]       ifm_row_q, ifm_row_d;
  logic                    end_frame_q, end_frame_d, cfg_err_q, cfg_err_d;

  logic [WE-1:0] step, row_w, col_w, h_w, w_w, need_row, oldest_row;
  logic          last_row, last_col, last_chn, need_loaded;
  logic          ring_reset, ifm_done_ok, pf_active;

  assign step     = stride2_q ? WE'(2) : WE'(1);
  assign row_w    = {1'b0, row_q};
  assign col_w    = {1'b0, col_q};
  assign h_w      = {1'b0, height_q};
  assign w_w      = {1'b0, width_q};
  assign last_row = (row_w + step) >= h_w;
  assign last_col = (col_w + step) >= w_w;
  assign last_chn = (chn_q == chans_q - 1'b1);
  // With a 3x3 kernel the row below must be resident, clamped at the bottom edge.
  assign need_row    = (kernel3_q && (row_w + WE'(1) < h_w)) ? row_w + WE'(1) : row_w;
  assign need_loaded = need_row < loaded_q;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    chans_d     = chans_q;
    tiles_d     = tiles_q;
    kernel3_d   = kernel3_q;
    stride2_d   = stride2_q;
    row_d       = row_q;
    col_d       = col_q;
    chn_d       = chn_q;
    tile_d      = tile_q;
    vcnt_d      = vcnt_q;
    hcnt_d      = hcnt_q;
    dcount_d    = dcount_q;
    pe_done_d   = pe_done_q;
    ifm_row_d   = ifm_row_q;
    flt_req_d   = 1'b0;
    ifm_req_d   = 1'b0;
    end_frame_d = 1'b0;
    cfg_err_d   = 1'b0;
    ring_reset  = 1'b0;
    if (q_pe_done && (state_q == S_DATA || state_q == S_WAIT_PE)) pe_done_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (q_start) begin
          width_d   = q_width;
          height_d  = q_height;
          chans_d   = q_channel;
          tiles_d   = q_out_tiles;
          kernel3_d = q_kernel3;
          stride2_d = q_stride2;
          if (q_width == '0 || q_height == '0 || q_channel == '0 || q_out_tiles == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d   = S_LOAD_FLT;
            flt_req_d = 1'b1;
            dcount_d  = '0;
            tile_d    = '0;
            row_d     = '0;
            col_d     = '0;
            chn_d     = '0;
          end
        end
      end
      S_LOAD_FLT: begin
        // A done pulse coincident with the request pulse is not a real completion.
        if (q_filter_buf_done && !flt_req_q) begin
          state_d    = S_VSYNC;
          vcnt_d     = '0;
          ring_reset = 1'b1;
        end
      end
      S_VSYNC: begin
        if (vcnt_q == W_DELAY'(VSYNC_DELAY - 1)) begin
          state_d = S_HSYNC;
          vcnt_d  = '0;
          hcnt_d  = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end
      S_HSYNC: begin
        if (hcnt_q == W_DELAY'(HSYNC_DELAY - 1)) begin
          if (need_loaded) begin
            state_d = S_DATA;
            hcnt_d  = '0;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_DATA: begin
        dcount_d = dcount_q + 1'b1;
        if (last_chn) begin
          chn_d = '0;
          if (last_col) begin
            col_d   = '0;
            state_d = S_WAIT_PE;
          end else begin
            col_d = col_q + step[W_SIZE-1:0];
          end
        end else begin
          chn_d = chn_q + 1'b1;
        end
      end
      S_WAIT_PE: begin
        if (pe_done_q) begin
          pe_done_d = 1'b0;
          if (!last_row) begin
            row_d   = row_q + step[W_SIZE-1:0];
            hcnt_d  = '0;
            state_d = S_HSYNC;
          end else begin
            row_d = '0;
            if (({1'b0, tile_q} + 1'b1) < {1'b0, tiles_q}) begin
              tile_d    = tile_q + 1'b1;
              flt_req_d = 1'b1;
              state_d   = S_LOAD_FLT;
            end else begin
              end_frame_d = 1'b1;
              state_d     = S_DONE;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Prefetch: one request in flight; a response left over from the previous tile is
    // marked stale so it is not credited to the fresh ring.
    ifm_done_ok = q_ifm_buf_done && pend_q && !ifm_req_q;
    pend_d      = pend_q && !ifm_done_ok;
    stale_d     = stale_q && !ifm_done_ok;
    loaded_d    = loaded_q + WE'(ifm_done_ok && !stale_q);
    nlr_d       = nlr_q;
    if (ring_reset) begin
      nlr_d    = '0;
      loaded_d = '0;
      stale_d  = pend_d;
    end
    pf_active  = (state_d == S_VSYNC) || (state_d == S_HSYNC) ||
                 (state_d == S_DATA)  || (state_d == S_WAIT_PE);
    oldest_row = (kernel3_q && row_d != '0) ? {1'b0, row_d} - WE'(1) : {1'b0, row_d};
    if (pf_active && !pend_d && nlr_d < h_w && nlr_d < oldest_row + WE'(IFM_BUF_CNT)) begin
      ifm_req_d = 1'b1;
      ifm_row_d = nlr_d[W_SIZE-1:0];
      nlr_d     = nlr_d + WE'(1);
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      chans_q     <= '0;
      tiles_q     <= '0;
      kernel3_q   <= 1'b0;
      stride2_q   <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      chn_q       <= '0;
      tile_q      <= '0;
      vcnt_q      <= '0;
      hcnt_q      <= '0;
      dcount_q    <= '0;
      pe_done_q   <= 1'b0;
      nlr_q       <= '0;
      loaded_q    <= '0;
      pend_q      <= 1'b0;
      stale_q     <= 1'b0;
      flt_req_q   <= 1'b0;
      ifm_req_q   <= 1'b0;
      ifm_row_q   <= '0;
      end_frame_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      chans_q     <= chans_d;
      tiles_q     <= tiles_d;
      kernel3_q   <= kernel3_d;
      stride2_q   <= stride2_d;
      row_q       <= row_d;
      col_q       <= col_d;
      chn_q       <= chn_d;
      tile_q      <= tile_d;
      vcnt_q      <= vcnt_d;
      hcnt_q      <= hcnt_d;
      dcount_q    <= dcount_d;
      pe_done_q   <= pe_done_d;
      nlr_q       <= nlr_d;
      loaded_q    <= loaded_d;
      pend_q      <= pend_d;
      stale_q     <= stale_d;
      flt_req_q   <= flt_req_d;
      ifm_req_q   <= ifm_req_d;
      ifm_row_q   <= ifm_row_d;
      end_frame_q <= end_frame_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  logic flag_valid;
  assign flag_valid = (state_q == S_HSYNC) || (state_q == S_DATA);

  assign o_filter_buf_req_load = flt_req_q;
  assign o_ifm_buf_req_load    = ifm_req_q;
  assign o_ifm_buf_req_row     = ifm_row_q;
  assign o_ifm_buf_req_slot    = ifm_row_q[W_IFM_BUF-1:0];
  assign o_ctrl_vsync_run      = (state_q == S_VSYNC);
  assign o_ctrl_hsync_run      = (state_q == S_HSYNC);
  assign o_ctrl_data_run       = (state_q == S_DATA);
  assign o_ctrl_vsync_cnt      = vcnt_q;
  assign o_ctrl_hsync_cnt      = hcnt_q;
  assign o_row                 = row_q;
  assign o_col                 = col_q;
  assign o_chn                 = chn_q;
  assign o_out_tile            = tile_q;
  assign o_is_first_row        = flag_valid && (row_q == '0);
  assign o_is_last_row         = flag_valid && last_row;
  assign o_is_first_col        = flag_valid && (col_q == '0);
  assign o_is_last_col         = flag_valid && last_col;
  assign o_data_count          = dcount_q;
  assign o_end_frame           = end_frame_q;
  assign o_busy                = (state_q != S_IDLE);
  assign o_cfg_err             = cfg_err_q;

endmodule
